// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer pixel writer.
// The address helper packs coordinates as {y,x}, i.e. y*FB_W + x for a 256-wide buffer.
package fb_pkg;

    localparam int FB_W_DEF       = 256;
    localparam int FB_H_DEF       = 256;
    localparam int COLOR_W_DEF    = 24;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int ADDR_W         = 16;
    localparam int PCOUNT_W       = 17;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } state_t;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/fb_pixel_writer_fifo.sv
// Synchronous pixel FIFO with a registered occupancy count; the head entry is
// visible combinationally on rdata so the output register can load it in one cycle.
module pixel_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Buffers renderer pixel beats and writes them to framebuffer memory through a
// valid/ready port; also runs a full-frame clear and reports frame completion.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int FB_W       = FB_W_DEF,
    parameter int FB_H       = FB_H_DEF,
    parameter int COLOR_W    = COLOR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pixel_valid,
    input  logic [7:0]          pixel_x,
    input  logic [7:0]          pixel_y,
    input  logic [COLOR_W-1:0]  pixel_color,
    input  logic                shape_done,
    input  logic                clear_start,
    input  logic [COLOR_W-1:0]  clear_color,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [COLOR_W-1:0]  mem_wr_data,
    input  logic                mem_wr_ready,
    output logic                busy,
    output logic                frame_done,
    output logic                overflow,
    output logic [PCOUNT_W-1:0] pixel_count
);

    localparam int ENTRY_W = ADDR_W + COLOR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(FB_W * FB_H - 1);
    localparam logic [PCOUNT_W-1:0] PCOUNT_MAX = PCOUNT_W'(FB_W * FB_H);

    state_t              state;
    logic [ADDR_W-1:0]   clear_addr;
    logic [COLOR_W-1:0]  clear_col;
    logic                clear_pend;
    logic                frame_flag;

    logic [ENTRY_W-1:0]  fifo_wdata;
    logic [ENTRY_W-1:0]  fifo_rdata;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    logic                in_range;
    logic                fifo_push;
    logic                pixel_drop;
    logic                accepted;
    logic                out_free;
    logic                start_req;
    logic                enter_clear;
    logic                clear_last_acc;
    logic                load_pix;
    logic                en_next;
    logic                clear_next;
    logic                pend_next;
    logic                flag_next;
    logic                done_next;
    logic [CNT_W-1:0]    fifo_cnt_next;
    logic [COLOR_W-1:0]  clear_data;

    assign in_range   = (32'(pixel_x) < FB_W) && (32'(pixel_y) < FB_H);
    assign fifo_wdata = {pix_addr(pixel_x, pixel_y), pixel_color};
    assign busy       = (state != IDLE) || !fifo_empty || mem_wr_en || clear_pend;

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (load_pix),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-cycle view of the datapath; frame_done is decided from these so it
    // can pulse in the cycle right after the final write is accepted.
    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        fifo_push      = pixel_valid && in_range && !fifo_full;
        pixel_drop     = pixel_valid && in_range && fifo_full;
        accepted       = mem_wr_en && mem_wr_ready;
        out_free       = !mem_wr_en || mem_wr_ready;
        start_req      = clear_start && (state != CLEAR);
        enter_clear    = (start_req || clear_pend) && out_free;
        pend_next      = (start_req || clear_pend) && !enter_clear;
        clear_last_acc = (state == CLEAR) && accepted && (clear_addr == LAST_ADDR);
        load_pix       = ((state != CLEAR) || clear_last_acc) && !start_req && !clear_pend
                         && !fifo_empty && out_free;
        clear_data     = start_req ? clear_color : clear_col;
        clear_next     = enter_clear || ((state == CLEAR) && !clear_last_acc);

        en_next = mem_wr_en;
        if (enter_clear || load_pix || ((state == CLEAR) && accepted && !clear_last_acc)) begin
            en_next = 1'b1;
        end else if (accepted) begin
            en_next = 1'b0;
        end

        fifo_cnt_next = fifo_count;
        if (fifo_push && !load_pix) begin
            fifo_cnt_next = fifo_count + CNT_W'(1);
        end else if (!fifo_push && load_pix) begin
            fifo_cnt_next = fifo_count - CNT_W'(1);
        end

        flag_next = frame_flag || shape_done;
        done_next = flag_next && (fifo_cnt_next == '0) && !en_next && !clear_next && !pend_next;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            clear_addr  <= '0;
            clear_col   <= '0;
            clear_pend  <= 1'b0;
            frame_flag  <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            pixel_count <= '0;
        end else begin
            mem_wr_en  <= en_next;
            clear_pend <= pend_next;
            frame_done <= done_next;
            frame_flag <= flag_next && !done_next;
            if (start_req) clear_col <= clear_color;

            if (enter_clear) begin
                state <= CLEAR;
            end else begin
                case (state)
                    IDLE:    if (!fifo_empty) state <= WRITE;
                    WRITE:   if (fifo_empty && out_free) state <= IDLE;
                    CLEAR:   if (clear_last_acc) state <= fifo_empty ? IDLE : WRITE;
                    default: state <= IDLE;
                endcase
            end

            // Clear writes walk the address only on acceptance; pixel writes load from the FIFO head.
            if (enter_clear) begin
                clear_addr  <= '0;
                mem_wr_addr <= '0;
                mem_wr_data <= clear_data;
            end else if (load_pix) begin
                mem_wr_addr <= fifo_rdata[ENTRY_W-1:COLOR_W];
                mem_wr_data <= fifo_rdata[COLOR_W-1:0];
            end else if ((state == CLEAR) && accepted && !clear_last_acc) begin
                clear_addr  <= clear_addr + ADDR_W'(1);
                mem_wr_addr <= clear_addr + ADDR_W'(1);
            end

            if (enter_clear) begin
                overflow <= 1'b0;
            end else if (pixel_drop) begin
                overflow <= 1'b1;
            end

            if (enter_clear) begin
                pixel_count <= '0;
            end else if (accepted && (state != CLEAR) && (pixel_count != PCOUNT_MAX)) begin
                pixel_count <= pixel_count + PCOUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: latency, throughput, overflow, stall
// stability, full clear with queued pixels, and reset during a clear.
module tb_fb_pixel_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pixel_valid;
    logic [7:0]  pixel_x;
    logic [7:0]  pixel_y;
    logic [23:0] pixel_color;
    logic        shape_done;
    logic        clear_start;
    logic [23:0] clear_color;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [23:0] mem_wr_data;
    logic        mem_wr_ready;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic [16:0] pixel_count;

    int errors = 0;
    int checks = 0;

    logic [15:0] wa[$];
    logic [23:0] wd[$];

    fb_pixel_writer dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_valid  (pixel_valid),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_color  (pixel_color),
        .shape_done   (shape_done),
        .clear_start  (clear_start),
        .clear_color  (clear_color),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .pixel_count  (pixel_count)
    );

    always #5 clk = ~clk;

    // Memory-side log of every accepted write, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && mem_wr_en && mem_wr_ready) begin
            wa.push_back(mem_wr_addr);
            wd.push_back(mem_wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %0h want 0", mem_wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0h want 0", frame_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0h want 0", overflow); end
        checks++; if (pixel_count !== 17'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", pixel_count); end
    endtask

    task automatic test_single();
        mem_wr_ready = 1'b1;
        pixel_valid  = 1'b1;
        shape_done   = 1'b1;
        pixel_x      = 8'd3;
        pixel_y      = 8'd5;
        pixel_color  = 24'hFF0000;
        tick();
        pixel_valid = 1'b0;
        shape_done  = 1'b0;
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL single_en_n1: got %0h want 0", mem_wr_en); end
        tick();
        checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL single_en_n2: got %0h want 1", mem_wr_en); end
        checks++; if (mem_wr_addr !== 16'h0503) begin errors++; $display("FAIL single_addr: got %h want 0503", mem_wr_addr); end
        checks++; if (mem_wr_data !== 24'hFF0000) begin errors++; $display("FAIL single_data: got %h want ff0000", mem_wr_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL single_fd_early: got %0h want 0", frame_done); end
        tick();
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL single_fd: got %0h want 1", frame_done); end
        checks++; if (pixel_count !== 17'd1) begin errors++; $display("FAIL single_count: got %0d want 1", pixel_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %0h want 0", busy); end
        tick();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL single_fd_pulse: got %0h want 0", frame_done); end
    endtask

    task automatic test_back_to_back();
        mem_wr_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            pixel_valid = (c < 6);
            pixel_x     = 8'(20 + c);
            pixel_y     = 8'd7;
            pixel_color = 24'(c);
            tick();
            if (c >= 1 && c <= 6) begin
                checks++;
                if (mem_wr_en !== 1'b1 || mem_wr_addr !== {8'd7, 8'(19 + c)}) begin
                    errors++;
                    $display("FAIL b2b_write%0d: got en=%0h addr=%h want en=1 addr=%h",
                             c - 1, mem_wr_en, mem_wr_addr, {8'd7, 8'(19 + c)});
                end
            end
        end
        pixel_valid = 1'b0;
        checks++; if (pixel_count !== 17'd7) begin errors++; $display("FAIL b2b_count: got %0d want 7", pixel_count); end
    endtask

    task automatic test_burst_overflow();
        int n;
        wa.delete();
        wd.delete();
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pixel_valid = 1'b1;
            pixel_x     = 8'(i);
            pixel_y     = 8'd1;
            pixel_color = 24'h100 + 24'(i);
            tick();
        end
        pixel_valid = 1'b0;
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow: got %0h want 1", overflow); end
        checks++; if (mem_wr_addr !== 16'h0100) begin errors++; $display("FAIL burst_head: got %h want 0100", mem_wr_addr); end
        mem_wr_ready = 1'b1;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_drain_timeout: busy got %0h want 0", busy); end
        checks++; if (wa.size() !== 17) begin errors++; $display("FAIL burst_writes: got %0d want 17", wa.size()); end
        if (wa.size() == 17) begin
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (wa[i] !== {8'd1, 8'(i)} || wd[i] !== 24'h100 + 24'(i)) begin
                    errors++;
                    $display("FAIL burst_order%0d: got %h/%h want %h/%h", i, wa[i], wd[i],
                             {8'd1, 8'(i)}, 24'h100 + 24'(i));
                end
            end
        end
        checks++; if (pixel_count !== 17'd24) begin errors++; $display("FAIL burst_count: got %0d want 24", pixel_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_sticky: got %0h want 1", overflow); end
    endtask

    task automatic test_ready_toggle();
        logic        stall;
        logic [15:0] pa;
        logic [23:0] pd;
        wa.delete();
        wd.delete();
        for (int c = 0; c < 40; c++) begin
            pixel_valid  = (c < 8);
            pixel_x      = 8'(10 + c);
            pixel_y      = 8'd2;
            pixel_color  = 24'h111 * 24'(c);
            mem_wr_ready = (c % 2 == 0);
            stall = mem_wr_en && !mem_wr_ready;
            pa    = mem_wr_addr;
            pd    = mem_wr_data;
            tick();
            if (stall) begin
                checks++;
                if (mem_wr_en !== 1'b1 || mem_wr_addr !== pa || mem_wr_data !== pd) begin
                    errors++;
                    $display("FAIL toggle_stable: got en=%0h %h/%h want en=1 %h/%h",
                             mem_wr_en, mem_wr_addr, mem_wr_data, pa, pd);
                end
            end
        end
        pixel_valid  = 1'b0;
        mem_wr_ready = 1'b1;
        checks++; if (wa.size() !== 8) begin errors++; $display("FAIL toggle_writes: got %0d want 8", wa.size()); end
        if (wa.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wa[i] !== {8'd2, 8'(10 + i)} || wd[i] !== 24'h111 * 24'(i)) begin
                    errors++;
                    $display("FAIL toggle_order%0d: got %h/%h want %h/%h", i, wa[i], wd[i],
                             {8'd2, 8'(10 + i)}, 24'h111 * 24'(i));
                end
            end
        end
        checks++; if (pixel_count !== 17'd32) begin errors++; $display("FAIL toggle_count: got %0d want 32", pixel_count); end
    endtask

    task automatic test_clear_with_pixels();
        int fd_cnt;
        int fd_size;
        int first_bad;
        wa.delete();
        wd.delete();
        mem_wr_ready = 1'b1;
        clear_color  = 24'h00FF00;
        clear_start  = 1'b1;
        tick();
        clear_start = 1'b0;
        clear_color = 24'h123456;
        checks++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'h0000) begin errors++; $display("FAIL clear_first: got en=%0h addr=%h want en=1 addr=0000", mem_wr_en, mem_wr_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy: got %0h want 1", busy); end
        checks++; if (pixel_count !== 17'd0) begin errors++; $display("FAIL clear_count_reset: got %0d want 0", pixel_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow_reset: got %0h want 0", overflow); end
        fd_cnt  = 0;
        fd_size = -1;
        for (int c = 0; c < 70000; c++) begin
            pixel_valid = (c >= 100 && c < 104);
            pixel_x     = 8'(40 + c - 100);
            pixel_y     = 8'd9;
            pixel_color = 24'hABC000 + 24'(c - 100);
            shape_done  = (c == 200);
            tick();
            if (frame_done) begin
                fd_cnt++;
                fd_size = wa.size();
            end
            if (!busy) break;
        end
        pixel_valid = 1'b0;
        shape_done  = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_timeout: busy got %0h want 0", busy); end
        checks++; if (wa.size() !== 65540) begin errors++; $display("FAIL clear_writes: got %0d want 65540", wa.size()); end
        first_bad = -1;
        if (wa.size() == 65540) begin
            for (int i = 0; i < 65536; i++) begin
                if (wa[i] !== 16'(i) || wd[i] !== 24'h00FF00) begin
                    first_bad = i;
                    break;
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wa[65536 + i] !== {8'd9, 8'(40 + i)} || wd[65536 + i] !== 24'hABC000 + 24'(i)) begin
                    errors++;
                    $display("FAIL clear_pixel%0d: got %h/%h want %h/%h", i, wa[65536 + i], wd[65536 + i],
                             {8'd9, 8'(40 + i)}, 24'hABC000 + 24'(i));
                end
            end
        end
        checks++; if (first_bad !== -1) begin errors++; $display("FAIL clear_sequence: first bad index %0d want none", first_bad); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL clear_fd_count: got %0d want 1", fd_cnt); end
        checks++; if (fd_size !== 65540) begin errors++; $display("FAIL clear_fd_timing: writes at frame_done %0d want 65540", fd_size); end
        checks++; if (pixel_count !== 17'd4) begin errors++; $display("FAIL clear_count_after: got %0d want 4", pixel_count); end
    endtask

    task automatic test_reset_mid_clear();
        mem_wr_ready = 1'b1;
        clear_color  = 24'h0000FF;
        clear_start  = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            shape_done  = (c == 10);
            pixel_valid = (c == 20);
            pixel_x     = 8'd1;
            pixel_y     = 8'd1;
            tick();
        end
        shape_done  = 1'b0;
        pixel_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstclr_busy_before: got %0h want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rstclr_en: got %0h want 0", mem_wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstclr_busy: got %0h want 0", busy); end
        checks++; if (pixel_count !== 17'd0) begin errors++; $display("FAIL rstclr_count: got %0d want 0", pixel_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstclr_overflow: got %0h want 0", overflow); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (frame_done !== 1'b0 || mem_wr_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstclr_quiet%0d: got fd=%0h en=%0h busy=%0h want 0/0/0", c, frame_done, mem_wr_en, busy);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        pixel_valid  = 1'b0;
        pixel_x      = '0;
        pixel_y      = '0;
        pixel_color  = '0;
        shape_done   = 1'b0;
        clear_start  = 1'b0;
        clear_color  = '0;
        mem_wr_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_burst_overflow();
        test_ready_toggle();
        test_clear_with_pixels();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
